// File: rtl/ball_sprite_engine.sv
// Single square ball sprite: per-frame motion with wall bounce, plus RGB565 pixel render.
// Optional macro CROSSHAIR_EN adds blue/red guide bands through the ball on background pixels.
module ball_sprite_engine #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned BALL_SIZE  = 4,
    parameter int unsigned H_INIT     = 128,
    parameter int unsigned V_INIT     = 128,
    parameter int unsigned H_STEP     = 2,
    parameter int unsigned V_STEP     = 2,
    parameter logic [15:0] BALL_COLOR = 16'hFFFF,
    parameter logic [15:0] BG_COLOR   = 16'h0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        vsync_i,
    input  logic [15:0] hpos_i,
    input  logic [15:0] vpos_i,
    input  logic        enable_i,
    output logic [15:0] rgb_o,
    output logic        frame_tick_o,
    output logic        hit_o,
    output logic [15:0] ball_x_o,
    output logic [15:0] ball_y_o
);

    localparam int unsigned W = 16;
    localparam logic [W-1:0] X_MAX  = W'(H_ACTIVE - BALL_SIZE);
    localparam logic [W-1:0] Y_MAX  = W'(V_ACTIVE - BALL_SIZE);
    localparam logic [W-1:0] DX_POS = W'(H_STEP);
    localparam logic [W-1:0] DX_NEG = W'(0) - DX_POS;
    localparam logic [W-1:0] DY_POS = W'(V_STEP);
    localparam logic [W-1:0] DY_NEG = W'(0) - DY_POS;
    localparam logic [W-1:0] SIZE   = W'(BALL_SIZE);

    typedef enum logic [1:0] {IDLE, STEP, CHECK} state_e;

    state_e        state_q, state_d;
    logic          vsync_q, tick_q, hit_q;
    logic [W-1:0]  x_q, y_q, dx_q, dy_q, x_d, y_d, dx_d, dy_d;
    logic [W:0]    nx_q, ny_q;
    logic [W-1:0]  rgb_q, rgb_d;
    logic          step_c, commit_c, hit_x_c, hit_y_c;
    logic [W-1:0]  hd_c, vd_c;
    logic          in_h_c, in_v_c;

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state: a tick outside IDLE is dropped
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tick_q && enable_i) state_d = STEP;
            STEP:    state_d = CHECK;
            CHECK:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        step_c   = 1'b0;
        commit_c = 1'b0;
        case (state_q)
            STEP:    step_c   = 1'b1;
            CHECK:   commit_c = 1'b1;
            default: ;
        endcase
    end

    // Clamp and reflect; bit W of the 17-bit candidate is its sign
    always_comb begin
        x_d     = nx_q[W-1:0];
        dx_d    = dx_q;
        hit_x_c = 1'b0;
        if (nx_q[W]) begin
            x_d = '0; dx_d = DX_POS; hit_x_c = 1'b1;
        end else if (nx_q[W-1:0] > X_MAX) begin
            x_d = X_MAX; dx_d = DX_NEG; hit_x_c = 1'b1;
        end
        y_d     = ny_q[W-1:0];
        dy_d    = dy_q;
        hit_y_c = 1'b0;
        if (ny_q[W]) begin
            y_d = '0; dy_d = DY_POS; hit_y_c = 1'b1;
        end else if (ny_q[W-1:0] > Y_MAX) begin
            y_d = Y_MAX; dy_d = DY_NEG; hit_y_c = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            vsync_q <= 1'b1;
            tick_q  <= 1'b0;
            hit_q   <= 1'b0;
            x_q     <= W'(H_INIT);
            y_q     <= W'(V_INIT);
            dx_q    <= DX_NEG;
            dy_q    <= DY_POS;
            nx_q    <= '0;
            ny_q    <= '0;
            rgb_q   <= '0;
        end else begin
            vsync_q <= vsync_i;
            tick_q  <= ~vsync_q & vsync_i;
            hit_q   <= commit_c & (hit_x_c | hit_y_c);
            rgb_q   <= rgb_d;
            if (step_c) begin
                nx_q <= {1'b0, x_q} + {dx_q[W-1], dx_q};
                ny_q <= {1'b0, y_q} + {dy_q[W-1], dy_q};
            end
            if (commit_c) begin
                x_q  <= x_d;
                y_q  <= y_d;
                dx_q <= dx_d;
                dy_q <= dy_d;
            end
        end
    end

    // Wrapping difference makes pixels left/above the ball compare as huge
    assign hd_c   = hpos_i - x_q;
    assign vd_c   = vpos_i - y_q;
    assign in_h_c = hd_c < SIZE;
    assign in_v_c = vd_c < SIZE;

    always_comb begin
        rgb_d = BG_COLOR;
        if (in_h_c && in_v_c) rgb_d = BALL_COLOR;
`ifdef CROSSHAIR_EN
        else if (in_h_c)      rgb_d = 16'h001F;
        else if (in_v_c)      rgb_d = 16'hF800;
`else
`endif
    end

    assign rgb_o        = rgb_q;
    assign frame_tick_o = tick_q;
    assign hit_o        = hit_q;
    assign ball_x_o     = x_q;
    assign ball_y_o     = y_q;

endmodule
